// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester (inst/data) SRAM-like bus arbiter with an in-order response ID FIFO.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-inst priority.
module sram_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

    state_t state, state_nxt;
    logic [OUTSTANDING-1:0] ids;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic full, pick_d, grant_i, grant_d, push, pop, head;

    assign full = count == CW'(OUTSTANDING);

`ifdef ARB_ROUND_ROBIN_EN
    // last_d=0 means inst won the last handshake, so data is favoured next
    logic last_d;
    assign pick_d = data_req && (!inst_req || !last_d);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            last_d <= 1'b0;
        else if (push)
            last_d <= grant_d;
`else
    assign pick_d = data_req;
`endif

    // Grants are gated by reset so strobes drop the moment reset asserts
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        state_nxt = state;
        if (!reset && !full)
            case (state)
                IDLE: begin
                    grant_d = pick_d;
                    grant_i = inst_req && !pick_d;
                    state_nxt = bus_addr_ok ? IDLE : grant_d ? HOLD_D : grant_i ? HOLD_I : IDLE;
                end
                HOLD_I: begin
                    grant_i = inst_req;
                    state_nxt = inst_req && !bus_addr_ok ? HOLD_I : IDLE;
                end
                HOLD_D: begin
                    grant_d = data_req;
                    state_nxt = data_req && !bus_addr_ok ? HOLD_D : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
    end

    assign bus_req = grant_i || grant_d;
    assign bus_wr = grant_d ? data_wr : inst_wr;
    assign bus_size = grant_d ? data_size : inst_size;
    assign bus_wstrb = grant_d ? data_wstrb : inst_wstrb;
    assign bus_addr = grant_d ? data_addr : inst_addr;
    assign bus_wdata = grant_d ? data_wdata : inst_wdata;

    assign inst_addr_ok = grant_i && bus_addr_ok;
    assign data_addr_ok = grant_d && bus_addr_ok;
    assign push = bus_req && bus_addr_ok;
    assign pop = !reset && bus_data_ok && count != '0;
    assign head = ids[rptr];
    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ids <= '0;
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                ids[wptr] <= grant_d;
                wptr <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk)
        if (!reset && bus_data_ok)
            assert (count != '0) else $warning("bus_data_ok with no outstanding transaction ignored");
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus for sram_arbiter, checked every cycle against a
// transaction-level model (owner hold, ID queue, arbitration rule) plus literal expectations.
module tb_sram_arbiter;
    localparam int N = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
    logic [1:0] inst_size = 0, data_size = 0;
    logic [3:0] inst_wstrb = 0, data_wstrb = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
    logic bus_addr_ok = 0, bus_data_ok = 0;
    logic [31:0] bus_rdata = 0;
    logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic bus_req, bus_wr;
    logic [1:0] bus_size;
    logic [3:0] bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;

    always #5 clk = ~clk;

    sram_arbiter #(.OUTSTANDING(N)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: held = requester owning the channel after a refused grant (-1 none, 0 inst, 1 data),
    // last = requester of the last accepted transaction, q = IDs awaiting responses.
    int held = -1;
    int last = 0;
    int q[$];

    always @(negedge clk) begin
        int win, head;
        win = -1;
        head = -1;
        if (!reset && q.size() < N) begin
            if (held == 0)
                win = inst_req ? 0 : -1;
            else if (held == 1)
                win = data_req ? 1 : -1;
            else if (inst_req && data_req)
                win = (RR && last == 1) ? 0 : 1;
            else if (data_req)
                win = 1;
            else if (inst_req)
                win = 0;
        end
        if (!reset && bus_data_ok && q.size() > 0)
            head = q[0];
        check("bus_req", 32'(bus_req), 32'(win >= 0));
        if (win >= 0) begin
            check("bus_addr", bus_addr, win == 1 ? data_addr : inst_addr);
            check("bus_wdata", bus_wdata, win == 1 ? data_wdata : inst_wdata);
            check("bus_wr", 32'(bus_wr), 32'(win == 1 ? data_wr : inst_wr));
        end
        check("inst_addr_ok", 32'(inst_addr_ok), 32'(win == 0 && bus_addr_ok));
        check("data_addr_ok", 32'(data_addr_ok), 32'(win == 1 && bus_addr_ok));
        check("inst_data_ok", 32'(inst_data_ok), 32'(head == 0));
        check("data_data_ok", 32'(data_data_ok), 32'(head == 1));
        if (head >= 0)
            check("rdata", head == 1 ? data_rdata : inst_rdata, bus_rdata);
        if (reset) begin
            q.delete();
            held = -1;
            last = 0;
        end else begin
            if (head >= 0)
                void'(q.pop_front());
            if (win >= 0 && bus_addr_ok) begin
                q.push_back(win);
                last = win;
                held = -1;
            end else if (q.size() < N)
                held = win;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] grants;
        repeat (2) cyc();
        check("reset bus_req", 32'(bus_req), 0);
        check("reset data_ok", 32'({inst_data_ok, data_data_ok}), 0);
        reset = 0;
        cyc();
        // both requesters in IDLE, accepted at once: data wins
        inst_addr = 32'h100; data_addr = 32'h200; inst_wdata = 32'hA1; data_wdata = 32'hD1; data_wr = 1;
        inst_req = 1; data_req = 1; bus_addr_ok = 1;
        #1;
        check("both data_addr_ok", 32'(data_addr_ok), 1);
        check("both inst_addr_ok", 32'(inst_addr_ok), 0);
        check("both bus_addr", bus_addr, 32'h200);
        cyc();
        inst_req = 0; data_req = 0; bus_addr_ok = 0; data_wr = 0;
        bus_data_ok = 1; bus_rdata = 32'hAA;
        #1;
        check("head is data", 32'({inst_data_ok, data_data_ok}), 32'b01);
        cyc();
        bus_data_ok = 0;
        // inst held for 3 refused cycles while data waits
        inst_req = 1; inst_addr = 32'h10; data_addr = 32'h20;
        #1;
        check("hold c0 bus_addr", bus_addr, 32'h10);
        cyc();
        data_req = 1;
        #1;
        check("hold c1 bus_addr", bus_addr, 32'h10);
        cyc();
        #1;
        check("hold c2 bus_addr", bus_addr, 32'h10);
        cyc();
        bus_addr_ok = 1;
        #1;
        check("hold c3 inst_addr_ok", 32'(inst_addr_ok), 1);
        check("hold c3 data_addr_ok", 32'(data_addr_ok), 0);
        cyc();
        inst_req = 0;
        #1;
        check("hold c4 data_addr_ok", 32'(data_addr_ok), 1);
        check("hold c4 bus_addr", bus_addr, 32'h20);
        cyc();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h5;
        #1;
        check("drain inst first", 32'(inst_data_ok), 1);
        cyc();
        bus_rdata = 32'h6;
        cyc();
        bus_data_ok = 0;
        // inst, data, inst accepted, then in-order responses
        bus_addr_ok = 1; inst_req = 1;
        cyc();
        inst_req = 0; data_req = 1;
        cyc();
        data_req = 0; inst_req = 1;
        cyc();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h11;
        #1;
        check("resp1 inst_data_ok", 32'(inst_data_ok), 1);
        check("resp1 inst_rdata", inst_rdata, 32'h11);
        check("resp1 data_data_ok", 32'(data_data_ok), 0);
        cyc();
        bus_rdata = 32'h22;
        #1;
        check("resp2 data_data_ok", 32'(data_data_ok), 1);
        check("resp2 data_rdata", data_rdata, 32'h22);
        cyc();
        bus_rdata = 32'h33;
        #1;
        check("resp3 inst_data_ok", 32'(inst_data_ok), 1);
        check("resp3 inst_rdata", inst_rdata, 32'h33);
        cyc();
        bus_data_ok = 0;
        // held owner drops its request: no transaction, channel released
        inst_req = 1;
        cyc();
        inst_req = 0; data_req = 1;
        #1;
        check("drop bus_req", 32'(bus_req), 0);
        cyc();
        #1;
        check("after drop bus_addr", bus_addr, 32'h20);
        cyc();
        data_req = 0;
        cyc();
        // fill the ID FIFO, then one response frees a slot for the next cycle only
        inst_req = 1; bus_addr_ok = 1;
        repeat (4) cyc();
        #1;
        check("full bus_req", 32'(bus_req), 0);
        check("full inst_addr_ok", 32'(inst_addr_ok), 0);
        cyc();
        bus_data_ok = 1; bus_rdata = 32'h77;
        #1;
        check("full pop no bypass", 32'(bus_req), 0);
        check("full pop inst_data_ok", 32'(inst_data_ok), 1);
        cyc();
        bus_data_ok = 0;
        #1;
        check("freed bus_req", 32'(bus_req), 1);
        check("freed inst_addr_ok", 32'(inst_addr_ok), 1);
        cyc();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        repeat (4) cyc();
        bus_data_ok = 0;
        cyc();
        // continuous contention: alternating grants with round robin, data every time otherwise
        inst_req = 1; data_req = 1; bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            grants[i] = data_addr_ok;
            check("contend inst_addr_ok", 32'(inst_addr_ok), 32'(!data_addr_ok));
            cyc();
            bus_data_ok = 1;
        end
        check("contend grant pattern", 32'(grants), RR ? 32'b0101 : 32'b1111);
        inst_req = 0; data_req = 0; bus_addr_ok = 0;
        cyc();
        bus_data_ok = 0;
        // reset with two outstanding transactions
        inst_req = 1; bus_addr_ok = 1;
        repeat (2) cyc();
        bus_data_ok = 1;
        #1;
        check("pre-reset strobes", 32'({inst_addr_ok, inst_data_ok}), 32'b11);
        reset = 1;
        #1;
        check("reset bus_req async", 32'(bus_req), 0);
        check("reset addr_ok async", 32'({inst_addr_ok, data_addr_ok}), 0);
        check("reset data_ok async", 32'({inst_data_ok, data_data_ok}), 0);
        cyc();
        reset = 0; inst_req = 0; bus_addr_ok = 0;
        #1;
        check("stale data_ok", 32'({inst_data_ok, data_data_ok}), 0);
        cyc();
        bus_data_ok = 0;
        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
